// File: rtl/rr_replay_unpacker.sv
// Unpacks LSB-first packed log units from trace beats, one unit per handshake (RR_UNPACK_TRUNC_CHECK_EN: sticky err on truncated tail).
// Latency: a unit completed by a beat accepted at edge N is presented right after edge N; one unit per cycle sustained.
// Backpressure: beats are refused while more than one full unit is buffered; a unit holds stable while out_ready is low.
package rr_replay_unpacker_pkg;
    function automatic int sum_fields(input logic [1023:0] flat, input int cnt, input int bits);
        int s;
        logic [1023:0] sh;
        s = 0;
        for (int i = 0; i < cnt; i++) begin
            sh = flat >> (i * bits);
            s  = s + int'(sh[31:0] & ((32'd1 << bits) - 32'd1));
        end
        return s;
    endfunction
endpackage

module rr_replay_unpacker #(
    parameter int LOGB_CHANNEL_CNT      = 4,
    parameter int RR_CHANNEL_WIDTH_BITS = 16,
    parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
        {16'd64, 16'd32, 16'd16, 16'd8},
    parameter int LOGE_CHANNEL_CNT      = 2,
    parameter int AXI_WIDTH             = 512,
    localparam int HDR          = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
    localparam int FULL_WIDTH   = HDR + rr_replay_unpacker_pkg::sum_fields(
                                      1024'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT, RR_CHANNEL_WIDTH_BITS),
    localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    restart,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AXI_WIDTH-1:0]    in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FULL_WIDTH-1:0]   out_data,
    output logic [OFFSET_WIDTH-1:0] out_len,
    output logic                    done,
    output logic [31:0]             unit_cnt,
    output logic                    err
);
    localparam int BUF   = AXI_WIDTH + FULL_WIDTH;
    localparam int FILLW = $clog2(BUF + 1);
    localparam logic [FILLW-1:0] HDR_F  = FILLW'(HDR);
    localparam logic [FILLW-1:0] FULL_F = FILLW'(FULL_WIDTH);
    localparam logic [FILLW-1:0] AXI_F  = FILLW'(AXI_WIDTH);

    typedef enum logic [1:0] {ST_FILL, ST_DRAIN, ST_DONE} state_t;

    state_t                  state, state_nxt;
    logic [BUF-1:0]          sbuf, buf_nxt, buf_shift;
    logic [FILLW-1:0]        fill, fill_nxt, fill_rem;
    logic [OFFSET_WIDTH-1:0] len;
    logic [FILLW-1:0]        len_f;
    logic [FULL_WIDTH-1:0]   len_mask;
    logic                    hdr_zero, unit_avail, accept, consume, armed;

    // Unit length comes straight from the logb bitmap at the bottom of the buffer.
    always_comb begin
        len = OFFSET_WIDTH'(HDR);
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            if (sbuf[i]) len = len + OFFSET_WIDTH'(CHANNEL_WIDTHS[i]);
        end
    end

    assign len_f      = FILLW'(len);
    assign hdr_zero   = (sbuf[HDR-1:0] == '0);
    assign unit_avail = (fill >= HDR_F) && (fill >= len_f);
    assign len_mask   = ~({FULL_WIDTH{1'b1}} << len);

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        state_nxt = state;
        case (state)
            ST_FILL: begin
                in_ready  = armed && (fill <= FULL_F);
                out_valid = unit_avail;
                if (in_valid && in_ready && in_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Zero header after the last beat is padding, not a unit.
                out_valid = unit_avail && !hdr_zero;
                if (!out_valid) begin
                    done      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (restart) state_nxt = ST_FILL;
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;
    assign out_len  = out_valid ? len : '0;
    assign out_data = out_valid ? (sbuf[FULL_WIDTH-1:0] & len_mask) : '0;

    // New beat lands directly above whatever survives this cycle's consume.
    always_comb begin
        buf_shift = consume ? (sbuf >> len) : sbuf;
        fill_rem  = consume ? (fill - len_f) : fill;
        buf_nxt   = buf_shift;
        fill_nxt  = fill_rem;
        if (accept) begin
            buf_nxt  = buf_shift | (BUF'(in_data) << fill_rem);
            fill_nxt = fill_rem + AXI_F;
        end
        if (done) begin
            buf_nxt  = '0;
            fill_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_FILL;
            sbuf     <= '0;
            fill     <= '0;
            unit_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            state <= state_nxt;
            sbuf  <= buf_nxt;
            fill  <= fill_nxt;
            armed <= 1'b1;
            if (state == ST_DONE && restart) unit_cnt <= '0;
            else if (consume)                unit_cnt <= unit_cnt + 32'd1;
        end
    end

`ifdef RR_UNPACK_TRUNC_CHECK_EN
    logic trunc;
    assign trunc = (state == ST_DRAIN) && (fill >= HDR_F) && !hdr_zero && (fill < len_f);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      err <= 1'b0;
        else if (trunc) err <= 1'b1;
    end

    trunc_chk: assert property (@(posedge clk) disable iff (!rstn) !trunc)
        else $error("rr_replay_unpacker: trace ends inside a unit");
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_replay_unpacker.sv
// Directed bench for rr_replay_unpacker: decode table plus multi-cycle trace sequences.
module tb_rr_replay_unpacker;
    logic         clk = 1'b0;
    logic         rstn, restart, in_valid, in_ready, in_last;
    logic         out_valid, out_ready, done, err;
    logic [511:0] in_data;
    logic [125:0] out_data;
    logic [6:0]   out_len;
    logic [31:0]  unit_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef RR_UNPACK_TRUNC_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    rr_replay_unpacker dut (
        .clk(clk), .rstn(rstn), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_len(out_len),
        .done(done), .unit_cnt(unit_cnt), .err(err)
    );

    typedef struct {
        logic [5:0]   hdr;
        logic [119:0] pay;
        int           len;
    } vec_t;

    vec_t         vecs[10];
    logic [511:0] bq_dat[$];
    logic         bq_last[$];
    logic [125:0] eq_dat[$];
    logic [6:0]   eq_len[$];
    logic [1023:0] stream;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_unit(input logic [125:0] d, input int len, input int pos);
        logic [126:0] m;
        logic [125:0] md;
        m  = (127'd1 << len) - 127'd1;
        md = d & m[125:0];
        stream = stream | (1024'(md) << pos);
        eq_dat.push_back(md);
        eq_len.push_back(7'(len));
    endtask

    task automatic push_beat(input logic [511:0] d, input logic last);
        bq_dat.push_back(d);
        bq_last.push_back(last);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic run_trace(input string tag, input bit want_done, input int ncyc,
                             input int stall_at, input int stall_n, input int exp_cnt);
        bit           got_done = 1'b0;
        bit           held     = 1'b0;
        logic [125:0] hd;
        logic [6:0]   hl;
        int           cyc = 0;
        while (cyc < ncyc && !got_done) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_n);
            if (done) begin
                got_done = 1'b1;
                chk({tag, " unit_cnt at done"}, 128'(unit_cnt), 128'(exp_cnt));
            end
            if (out_valid && out_ready) begin
                if (eq_dat.size() == 0)
                    chk({tag, " unexpected unit len"}, 128'(out_len), 128'(0));
                else begin
                    chk({tag, " len"}, 128'(out_len), 128'(eq_len.pop_front()));
                    chk({tag, " data"}, 128'(out_data), 128'(eq_dat.pop_front()));
                end
            end
            if (out_valid && !out_ready) begin
                if (held) begin
                    chk({tag, " held len"}, 128'(out_len), 128'(hl));
                    chk({tag, " held data"}, 128'(out_data), 128'(hd));
                end
                hd   = out_data;
                hl   = out_len;
                held = 1'b1;
            end else begin
                held = 1'b0;
            end
            if (stall_n > 0 && cyc == stall_at + stall_n - 1)
                chk({tag, " in_ready while full"}, 128'(in_ready), 128'(0));
            if (!got_done && bq_dat.size() > 0) begin
                in_valid = 1'b1;
                in_data  = bq_dat[0];
                in_last  = bq_last[0];
                if (in_ready) begin
                    void'(bq_dat.pop_front());
                    void'(bq_last.pop_front());
                end
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = '0;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        chk({tag, " done seen"}, 128'(got_done), 128'(want_done));
        chk({tag, " units missing"}, 128'(eq_dat.size()), 128'(0));
        @(negedge clk);
        if (!want_done) chk({tag, " unit_cnt"}, 128'(unit_cnt), 128'(exp_cnt));
        eq_dat.delete(); eq_len.delete(); bq_dat.delete(); bq_last.delete();
        stream = '0;
    endtask

    initial begin
        vecs[0] = '{6'b000001, 120'hA5C3_F00F_1234_5678_9ABC_DEF0_1357_9B, 14};
        vecs[1] = '{6'b000010, 120'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1, 22};
        vecs[2] = '{6'b000100, 120'hA5C3_F00F_1234_5678_9ABC_DEF0_1357_9B, 38};
        vecs[3] = '{6'b001000, 120'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1, 70};
        vecs[4] = '{6'b001111, 120'hA5C3_F00F_1234_5678_9ABC_DEF0_1357_9B, 126};
        vecs[5] = '{6'b000101, 120'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1, 46};
        vecs[6] = '{6'b001010, 120'hA5C3_F00F_1234_5678_9ABC_DEF0_1357_9B, 86};
        vecs[7] = '{6'b110001, 120'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1, 14};
        vecs[8] = '{6'b100110, 120'hA5C3_F00F_1234_5678_9ABC_DEF0_1357_9B, 54};
        vecs[9] = '{6'b010011, 120'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1, 30};

        rstn = 1'b1; restart = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; out_ready = 1'b1; stream = '0;
        #1 rstn = 1'b0;
        #2;
        chk("reset in_ready", 128'(in_ready), 128'(0));
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset done", 128'(done), 128'(0));
        chk("reset unit_cnt", 128'(unit_cnt), 128'(0));
        chk("reset err", 128'(err), 128'(0));
        chk("reset out_len", 128'(out_len), 128'(0));
        chk("reset out_data", 128'(out_data), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 128'(in_ready), 128'(1));

        // Non-last beat: the trailing zero header in FILL is a legal 6-bit unit.
        for (int k = 0; k < 36; k++)
            add_unit(126'({8'(k * 7 + 3), 6'b000001}), 14, 14 * k);
        add_unit('0, 6, 504);
        push_beat(stream[511:0], 1'b0);
        run_trace("pad_fill", 1'b0, 80, -1, 0, 37);
        pulse_restart();
        chk("restart in FILL unit_cnt", 128'(unit_cnt), 128'(37));
        chk("restart in FILL in_ready", 128'(in_ready), 128'(1));
        push_beat('0, 1'b1);
        run_trace("zero_tail", 1'b1, 50, -1, 0, 37);
        chk("DONE in_ready", 128'(in_ready), 128'(0));
        pulse_restart();
        chk("restart in DONE unit_cnt", 128'(unit_cnt), 128'(0));
        chk("restart in DONE in_ready", 128'(in_ready), 128'(1));

        for (int i = 0; i < 10; i++) begin
            add_unit({vecs[i].pay, vecs[i].hdr}, vecs[i].len, 0);
            push_beat(stream[511:0], 1'b1);
            run_trace($sformatf("vec%0d", i), 1'b1, 50, -1, 0, 1);
            pulse_restart();
        end

        for (int k = 0; k < 36; k++)
            add_unit(126'({8'(k * 5 + 1), 6'b000001}), 14, 14 * k);
        push_beat(stream[511:0], 1'b1);
        run_trace("len14x36", 1'b1, 100, -1, 0, 36);
        pulse_restart();

        // Unit 7 straddles the beat boundary; consumer stalls for 20 cycles.
        for (int k = 0; k < 8; k++)
            add_unit(126'({32'hC0DE_0000 | k, 32'h5A5A_5A00 | k, 6'b001000}), 70, 70 * k);
        push_beat(stream[511:0], 1'b0);
        push_beat(stream[1023:512], 1'b1);
        run_trace("span_stall", 1'b1, 120, 3, 20, 8);
        pulse_restart();

        for (int k = 0; k < 6; k++)
            add_unit(126'({64'h1111_2222_3333_4440 + 64'(k), 6'b001000}), 70, 70 * k);
        for (int k = 0; k < 3; k++)
            add_unit(126'({8'hE0 + 8'(k), 6'b000001}), 14, 420 + 14 * k);
        stream = stream | (1024'({44'hFFF_FFFF_FFFF, 6'b001000}) << 462);
        push_beat(stream[511:0], 1'b1);
        run_trace("trunc", 1'b1, 60, -1, 0, 9);
        chk("trunc err", 128'(err), 128'(EXP_ERR));
        chk("trunc DONE in_ready", 128'(in_ready), 128'(0));
        pulse_restart();

        for (int k = 0; k < 36; k++)
            add_unit(126'({8'(k), 6'b000001}), 14, 14 * k);
        eq_dat.delete(); eq_len.delete();
        @(negedge clk);
        in_valid = 1'b1; in_data = stream[511:0]; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        @(negedge clk);
        chk("drain out_valid before reset", 128'(out_valid), 128'(1));
        rstn = 1'b0;
        #1;
        chk("mid-drain reset out_valid", 128'(out_valid), 128'(0));
        chk("mid-drain reset done", 128'(done), 128'(0));
        chk("mid-drain reset unit_cnt", 128'(unit_cnt), 128'(0));
        chk("mid-drain reset err", 128'(err), 128'(0));
        chk("mid-drain reset in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        stream = '0;
        @(negedge clk);
        chk("after reset in_ready", 128'(in_ready), 128'(1));
        chk("after reset out_valid", 128'(out_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
